dfi_phy_loopback: RTL and testbench



---
 rtl/dfi_phy_loopback.sv | 202 ++++++++++++++++++++
 tb/tb_dfi_phy_loopback.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dfi_phy_loopback.sv
// PHY-side DFI responder: init/ctrlupd/low-power handshakes and a write-to-read
// loopback FIFO with programmable write-data and read-data latencies.

module dfi_byte_lane (
  input  logic [7:0] wr_byte,
  input  logic       mask,
  output logic [7:0] st_byte
);
  assign st_byte = mask ? 8'h00 : wr_byte;
endmodule

// Request-to-ack responder: ack after DLY consecutive request cycles, drops with the request.
module dfi_hs_ack #(
  parameter int DLY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic ack
);
  localparam int CW = $clog2(DLY + 1);
  logic [CW-1:0] run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run <= '0;
      ack <= 1'b0;
    end else if (!req) begin
      run <= '0;
      ack <= 1'b0;
    end else begin
      if (run != CW'(DLY)) run <= run + 1'b1;
      ack <= (int'(run) + 1) >= DLY;
    end
  end
endmodule

module dfi_phy_loopback #(
  parameter int C_DQ_WIDTH    = 64,
  parameter int C_DM_WIDTH    = 8,
  parameter int C_FIFO_DEPTH  = 16,
  parameter int C_INIT_CYCLES = 16,
  parameter int C_TPHY_WRDATA = 1,
  parameter int C_TRDDATA_EN  = 4,
  parameter int C_UPD_ACK_DLY = 2,
  parameter int C_LP_ACK_DLY  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dfi_init_start,
  output logic                  dfi_init_complete,
  input  logic                  dfi_wrdata_en,
  input  logic [C_DQ_WIDTH-1:0] dfi_wrdata,
  input  logic [C_DM_WIDTH-1:0] dfi_wrdata_mask,
  input  logic                  dfi_rddata_en,
  output logic [C_DQ_WIDTH-1:0] dfi_rddata,
  output logic                  dfi_rddata_valid,
  input  logic                  dfi_ctrlupd_req,
  output logic                  dfi_ctrlupd_ack,
  output logic                  dfi_phyupd_req,
  input  logic                  dfi_lp_ctrl_req,
  input  logic                  dfi_lp_data_req,
  output logic                  dfi_lp_ack,
  output logic                  dfi_error,
  output logic [2:0]            dfi_error_info
);
  localparam int AW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
  localparam int IW = $clog2(C_INIT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_DONE} state_t;

  state_t        state;
  logic [IW-1:0] init_cnt;
  logic          done;

  assign done           = (state == S_DONE);
  assign dfi_phyupd_req = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      init_cnt          <= '0;
      dfi_init_complete <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (dfi_init_start) begin
          state    <= S_INIT;
          init_cnt <= '0;
        end
        S_INIT: begin
          if (!dfi_init_start) state <= S_IDLE;
          else if (init_cnt == IW'(C_INIT_CYCLES - 1)) begin
            state             <= S_DONE;
            dfi_init_complete <= 1'b1;
          end else init_cnt <= init_cnt + 1'b1;
        end
        S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write enable delay line; bus is sampled when the delayed enable emerges.
  logic wr_req, wr_go;
  assign wr_req = dfi_wrdata_en & done;

  generate
    if (C_TPHY_WRDATA == 0) begin : g_wr_nodly
      assign wr_go = wr_req;
    end else begin : g_wr_dly
      logic [C_TPHY_WRDATA-1:0] wr_dly;
      always_ff @(posedge clk) begin
        if (!rst_n) wr_dly <= '0;
        else begin
          wr_dly[0] <= wr_req;
          for (int i = 1; i < C_TPHY_WRDATA; i++) wr_dly[i] <= wr_dly[i-1];
        end
      end
      assign wr_go = wr_dly[C_TPHY_WRDATA-1];
    end
  endgenerate

  logic [C_DM_WIDTH-1:0][7:0] wr_word;

  generate
    for (genvar g = 0; g < C_DM_WIDTH; g++) begin : g_lane
      dfi_byte_lane u_lane (
        .wr_byte (dfi_wrdata[g*8 +: 8]),
        .mask    (dfi_wrdata_mask[g]),
        .st_byte (wr_word[g])
      );
    end
  endgenerate

  logic [C_DQ_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic [AW:0]           count;
  logic                  full, empty, rd_go, do_push, do_pop;
  logic [2:0]            err_now;

  assign full    = (count == (AW+1)'(C_FIFO_DEPTH));
  assign empty   = (count == '0);
  assign rd_go   = dfi_rddata_en & done;
  assign do_pop  = rd_go & ~empty;
  // A full FIFO still accepts a push when the same cycle pops.
  assign do_push = wr_go & (~full | rd_go);
  assign err_now = {~done & (dfi_wrdata_en | dfi_rddata_en), rd_go & empty, wr_go & full & ~rd_go};

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  logic [C_TRDDATA_EN:1]                 vld_pipe;
  logic [C_TRDDATA_EN:1][C_DQ_WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_go;
      dat_pipe[1] <= do_pop ? mem[rptr] : '0;
      for (int i = 2; i <= C_TRDDATA_EN; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign dfi_rddata       = dat_pipe[C_TRDDATA_EN];
  assign dfi_rddata_valid = vld_pipe[C_TRDDATA_EN];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dfi_error      <= 1'b0;
      dfi_error_info <= 3'b000;
    end else begin
      dfi_error <= |err_now;
      if (|err_now) dfi_error_info <= err_now;
    end
  end

  dfi_hs_ack #(.DLY(C_UPD_ACK_DLY)) u_upd (
    .clk (clk), .rst_n (rst_n), .req (dfi_ctrlupd_req), .ack (dfi_ctrlupd_ack)
  );

  dfi_hs_ack #(.DLY(C_LP_ACK_DLY)) u_lp (
    .clk (clk), .rst_n (rst_n), .req (dfi_lp_ctrl_req | dfi_lp_data_req), .ack (dfi_lp_ack)
  );
endmodule

// File: tb/tb_dfi_phy_loopback.sv
// Self-checking bench for dfi_phy_loopback: directed table, handshake sequences
// and randomized traffic against a queue-based reference model.

module tb_dfi_phy_loopback;
  localparam int DQ = 64, DM = 8, DEPTH = 16, INIT = 16, TPHY = 1, TRD = 4, UPD = 2, LP = 2;

  logic          clk = 1'b0;
  logic          rst_n, init_start, wr_en, rd_en, upd_req, lp_ctrl, lp_data;
  logic [DQ-1:0] wd;
  logic [DM-1:0] wm;
  logic          init_complete, rd_valid, upd_ack, phyupd, lp_ack, err;
  logic [DQ-1:0] rd_data;
  logic [2:0]    err_info;

  always #5 clk = ~clk;

  dfi_phy_loopback #(
    .C_DQ_WIDTH(DQ), .C_DM_WIDTH(DM), .C_FIFO_DEPTH(DEPTH), .C_INIT_CYCLES(INIT),
    .C_TPHY_WRDATA(TPHY), .C_TRDDATA_EN(TRD), .C_UPD_ACK_DLY(UPD), .C_LP_ACK_DLY(LP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dfi_init_start(init_start), .dfi_init_complete(init_complete),
    .dfi_wrdata_en(wr_en), .dfi_wrdata(wd), .dfi_wrdata_mask(wm),
    .dfi_rddata_en(rd_en), .dfi_rddata(rd_data), .dfi_rddata_valid(rd_valid),
    .dfi_ctrlupd_req(upd_req), .dfi_ctrlupd_ack(upd_ack), .dfi_phyupd_req(phyupd),
    .dfi_lp_ctrl_req(lp_ctrl), .dfi_lp_data_req(lp_data), .dfi_lp_ack(lp_ack),
    .dfi_error(err), .dfi_error_info(err_info)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model state
  logic [DQ-1:0] q[$];
  bit            m_done;
  int            start_run, upd_run, lp_run, cyc;
  bit            wpend[8];
  bit            ev[8];
  logic [DQ-1:0] ed[8];
  bit            e_err, e_cmp, e_upd, e_lp;
  logic [2:0]    e_info;

  function automatic logic [DQ-1:0] mask_word(input logic [DQ-1:0] d, input logic [DM-1:0] m);
    for (int b = 0; b < DM; b++) if (m[b]) d[b*8 +: 8] = 8'h00;
    return d;
  endfunction

  task automatic idle_in();
    init_start = 0; wr_en = 0; rd_en = 0; upd_req = 0; lp_ctrl = 0; lp_data = 0;
    wd = '0; wm = '0;
  endtask

  // Advance one cycle with current inputs, update the model, compare all outputs.
  task automatic step();
    logic [2:0] codes = 3'b000;
    int s;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 8; i++) begin wpend[i] = 0; ev[i] = 0; ed[i] = '0; end
      m_done = 0; start_run = 0; upd_run = 0; lp_run = 0;
      e_err = 0; e_info = 0; e_cmp = 0; e_upd = 0; e_lp = 0;
    end else begin
      if (!m_done && (wr_en || rd_en)) codes[2] = 1;
      if (m_done && rd_en) begin
        s = (cyc + TRD) % 8;
        ev[s] = 1;
        if (q.size() > 0) ed[s] = q.pop_front();
        else begin ed[s] = '0; codes[1] = 1; end
      end
      if (m_done && wr_en) wpend[(cyc + TPHY) % 8] = 1;
      if (wpend[cyc % 8]) begin
        wpend[cyc % 8] = 0;
        if (q.size() < DEPTH) q.push_back(mask_word(wd, wm));
        else codes[0] = 1;
      end
      start_run = init_start ? start_run + 1 : 0;
      if (start_run >= INIT + 1) m_done = 1;
      e_cmp = m_done;
      upd_run = upd_req ? upd_run + 1 : 0;
      lp_run  = (lp_ctrl || lp_data) ? lp_run + 1 : 0;
      e_upd = (upd_run >= UPD);
      e_lp  = (lp_run >= LP);
      e_err = (codes != 0);
      if (codes != 0) e_info = codes;
    end
    @(posedge clk); #1;
    cyc++;
    chk("init_complete", init_complete, e_cmp);
    chk("ctrlupd_ack", upd_ack, e_upd);
    chk("lp_ack", lp_ack, e_lp);
    chk("phyupd_req", phyupd, 0);
    chk("error", err, e_err);
    chk("error_info", err_info, e_info);
    chk("rddata_valid", rd_valid, ev[cyc % 8]);
    chk("rddata", rd_data, ev[cyc % 8] ? ed[cyc % 8] : '0);
    ev[cyc % 8] = 0; ed[cyc % 8] = '0;
  endtask

  typedef struct {
    bit            wr;
    logic [DQ-1:0] d;
    logic [DM-1:0] m;
    bit            rd;
    bit            xv;
    logic [DQ-1:0] xd;
  } vec_t;

  vec_t       tbl[10];
  logic [7:0] pat;
  int         lat, nv;

  initial begin
    tbl[0] = '{1, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 0, 0, 64'h0};
    tbl[1] = '{1, 64'h0123_4567_89AB_CDEF, 8'h00, 0, 0, 64'h0};
    tbl[2] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0, 64'h0};
    tbl[3] = '{0, 64'h0, 8'h00, 1, 0, 64'h0};
    tbl[4] = '{0, 64'h0, 8'h00, 1, 0, 64'h0};
    tbl[5] = '{0, 64'h0, 8'h00, 0, 0, 64'h0};
    tbl[6] = '{0, 64'h0, 8'h00, 0, 1, 64'h0123_4567_89AB_CDEF};
    tbl[7] = '{0, 64'h0, 8'h00, 0, 1, 64'hFFFF_FFFF_0000_0000};
    tbl[8] = '{0, 64'h0, 8'h00, 0, 0, 64'h0};
    tbl[9] = '{0, 64'h0, 8'h00, 0, 0, 64'h0};

    cyc = 0;
    idle_in();
    rst_n = 0;
    wr_en = 1; rd_en = 1; upd_req = 1; init_start = 1;
    step(); step();
    chk("reset_outs", {init_complete, rd_valid, rd_data, upd_ack, lp_ack, err, err_info}, '0);
    idle_in(); rst_n = 1;
    step();

    // Read before init
    rd_en = 1; step(); rd_en = 0;
    chk("preinit_err", {err, err_info}, 4'b1100);
    for (int i = 0; i < 6; i++) step();

    // Init abort after 5 INIT cycles, then a full restart
    init_start = 1;
    for (int i = 0; i < 6; i++) step();
    init_start = 0;
    for (int i = 0; i < 4; i++) step();
    chk("abort_complete", init_complete, 0);
    lat = 0;
    for (int i = 0; i < 40 && !init_complete; i++) begin init_start = 1; step(); lat++; end
    chk("init_latency", lat, INIT + 1);
    init_start = 0; step();

    // Directed loopback
    for (int i = 0; i < 10; i++) begin
      wr_en = tbl[i].wr; wd = tbl[i].d; wm = tbl[i].m; rd_en = tbl[i].rd;
      step();
      chk("tbl_valid", rd_valid, tbl[i].xv);
      chk("tbl_data", rd_data, tbl[i].xd);
    end
    idle_in();

    // 17 writes into a 16-deep FIFO
    for (int i = 0; i < 18; i++) begin
      wr_en = (i < 17); wd = {$urandom, $urandom}; wm = '0;
      step();
      if (i == 17) chk("full_err", {err, err_info}, 4'b1001);
    end
    // Push/pop aligned on a full FIFO: occupancy stays at 16
    for (int k = 0; k < 9; k++) begin
      wr_en = (k < 8); rd_en = (k >= 1); wd = {$urandom, $urandom};
      step();
    end
    idle_in();
    chk("simul_no_err", err_info, 3'b001);
    // 17 reads: 16 words then an empty read
    for (int i = 0; i < 22; i++) begin rd_en = (i < 17); step(); end
    chk("empty_err", err_info, 3'b010);
    idle_in();

    // ctrlupd held 6 cycles
    pat = '0;
    for (int i = 0; i < 8; i++) begin upd_req = (i < 6); step(); pat[i] = upd_ack; end
    chk("ctrlupd_pattern", pat, 8'b0011_1110);
    // 1-cycle lp_data pulse
    pat = '0;
    for (int i = 0; i < 5; i++) begin lp_data = (i == 0); step(); pat[i] = lp_ack; end
    chk("lp_pulse_noack", pat, 8'h00);
    idle_in();

    // Randomized traffic: write-heavy then read-heavy
    for (int i = 0; i < 600; i++) begin
      wr_en = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd_en = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      wd = {$urandom, $urandom};
      wm = ($urandom_range(0, 3) == 0) ? DM'($urandom) : '0;
      if ($urandom_range(0, 4) == 0) upd_req = ~upd_req;
      if ($urandom_range(0, 5) == 0) lp_ctrl = ~lp_ctrl;
      if ($urandom_range(0, 5) == 0) lp_data = ~lp_data;
      init_start = $urandom_range(0, 1);
      step();
    end
    idle_in();
    for (int i = 0; i < 6; i++) step();

    // Reset while a read is in flight
    wr_en = 1; wd = 64'h1111; step(); wd = 64'h2222; step();
    wr_en = 0; wd = 64'h3333; step();
    rd_en = 1; step(); rd_en = 0;
    rst_n = 0; step(); rst_n = 1;
    nv = 0;
    for (int i = 0; i < 6; i++) begin step(); nv += int'(rd_valid); end
    chk("reset_read_novalid", nv, 0);
    for (int i = 0; i < INIT + 1; i++) begin init_start = 1; step(); end
    init_start = 0; step();
    rd_en = 1; step(); rd_en = 0;
    for (int i = 0; i < 5; i++) step();
    chk("reset_fifo_empty", err_info, 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
